// File: rtl/tile_bl_wl_config_loader.sv
// Programming sequencer for one tile's bl/wl bank: assembles a bit-line frame
// from a word stream, then strobes the matching word line, row by row.
module tile_bl_wl_config_loader #(
    parameter int NUM_BL   = 160,
    parameter int NUM_WL   = 160,
    parameter int DATA_W   = 8,
    parameter int WL_PULSE = 2
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_last,
    output logic [0:NUM_BL-1] bl,
    output logic [0:NUM_WL-1] wl,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_dbg
);

    localparam int NUM_WORDS = (NUM_BL + DATA_W - 1) / DATA_W;
    localparam int WC_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int ROW_W     = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
    localparam int PC_W      = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_PULSE  = 3'd3,
        S_HOLD   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state, state_next;
    logic [WC_W-1:0]   word_cnt;
    logic [ROW_W-1:0]  row;
    logic [PC_W-1:0]   pulse_cnt;

    // Handshake: a word moves on any rising edge where cfg_valid && cfg_ready;
    // cfg_ready is a pure function of state (LOAD only), never of cfg_valid.
    logic xfer, word_last, frame_ok, frame_bad, start_ok, last_row, pulse_end;

    assign xfer      = cfg_valid && cfg_ready;
    assign word_last = (word_cnt == WC_W'(NUM_WORDS - 1));
    assign frame_ok  = xfer && cfg_last && word_last;
    assign frame_bad = xfer && (cfg_last != word_last);
    assign start_ok  = cfg_start && ((state == S_IDLE) || (state == S_DONE));
    assign last_row  = (row == ROW_W'(NUM_WL - 1));
    assign pulse_end = (pulse_cnt == PC_W'(WL_PULSE - 1));

    always_ff @(posedge prog_clk) begin
        if (prog_reset) state <= S_IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (cfg_start) state_next = S_LOAD;
            S_LOAD:   if (frame_ok) state_next = S_SETTLE;
            S_SETTLE: state_next = S_PULSE;
            S_PULSE:  if (pulse_end) state_next = S_HOLD;
            S_HOLD:   state_next = last_row ? S_DONE : S_LOAD;
            S_DONE:   if (cfg_start) state_next = S_LOAD;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state == S_LOAD);
        busy      = (state == S_LOAD) || (state == S_SETTLE) ||
                    (state == S_PULSE) || (state == S_HOLD);
        done      = (state == S_DONE);
        state_dbg = state;
        wl        = '0;
        if (state == S_PULSE) wl[row] = 1'b1;
    end

    // A malformed frame restarts the word count on the same row; the row only
    // advances after its word line has been strobed.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            row       <= '0;
            word_cnt  <= '0;
            pulse_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (start_ok) begin
                row      <= '0;
                word_cnt <= '0;
                err      <= 1'b0;
            end else if (xfer) begin
                if (frame_bad) err <= 1'b1;
                if (frame_bad || frame_ok) word_cnt <= '0;
                else                       word_cnt <= word_cnt + 1'b1;
            end else if (state == S_HOLD && !last_row) begin
                row      <= row + 1'b1;
                word_cnt <= '0;
            end
            if (state == S_PULSE && !pulse_end) pulse_cnt <= pulse_cnt + 1'b1;
            else                                pulse_cnt <= '0;
        end
    end

    // Word k lands on bl[k*DATA_W +: DATA_W]; bits past NUM_BL fall off.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            bl <= '0;
        end else begin
            for (int j = 0; j < NUM_BL; j++) begin
                if (xfer && word_cnt == WC_W'(j / DATA_W)) bl[j] <= cfg_data[j % DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_tile_bl_wl_config_loader.sv
// Randomised bench for tile_bl_wl_config_loader: default-size bank against a
// frame-level scoreboard, plus a small 20x2 bank with a one-cycle pulse.
module tb_tile_bl_wl_config_loader;

    localparam int A_BL = 160, A_WL = 160, DW = 8, A_P = 2, A_W = 20;
    localparam int B_BL = 20,  B_WL = 2,   B_P = 1;

    typedef logic [0:A_BL-1] abl_t;

    logic clk = 1'b0;
    int   cyc = 0;

    // instance A (defaults)
    logic          rst, start, valid, last;
    logic [DW-1:0] data;
    logic          ready, busy, done, err;
    abl_t          bl;
    logic [0:A_WL-1] wl;
    logic [2:0]    st_dbg;

    // instance B (20 bit lines, 2 rows, 1-cycle pulse)
    logic          b_rst, b_start, b_valid, b_last;
    logic [DW-1:0] b_data;
    logic          b_ready, b_busy, b_done, b_err;
    logic [0:B_BL-1] b_bl;
    logic [0:B_WL-1] b_wl;
    logic [2:0]    b_st_dbg;

    tile_bl_wl_config_loader dut_a (
        .prog_clk(clk), .prog_reset(rst), .cfg_start(start), .cfg_valid(valid),
        .cfg_ready(ready), .cfg_data(data), .cfg_last(last), .bl(bl), .wl(wl),
        .busy(busy), .done(done), .err(err), .state_dbg(st_dbg)
    );

    tile_bl_wl_config_loader #(.NUM_BL(B_BL), .NUM_WL(B_WL), .DATA_W(DW), .WL_PULSE(B_P)) dut_b (
        .prog_clk(clk), .prog_reset(b_rst), .cfg_start(b_start), .cfg_valid(b_valid),
        .cfg_ready(b_ready), .cfg_data(b_data), .cfg_last(b_last), .bl(b_bl), .wl(b_wl),
        .busy(b_busy), .done(b_done), .err(b_err), .state_dbg(b_st_dbg)
    );

    // clock / reset-time bookkeeping
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // scoreboard: one entry per well-formed frame
    abl_t exp_q[$];
    int   exp_row_q[$];
    int   exp_t_q[$];
    abl_t model_bl = '0;
    int   model_row = 0;
    bit   exp_err = 0;
    int   last_t = -100;
    int   rdy_chk = -1;
    int   pulses_seen = 0;
    bit   mon_abort = 0;

    // monitor: word-line pulses checked against the scoreboard
    bit   in_pulse = 0;
    int   plen, prow, mr, et, er;
    abl_t eb;
    always @(negedge clk) begin
        if (wl != '0) begin
            check_eq("wl_onehot", $countones(wl), 1);
            mr = -1;
            for (int i = 0; i < A_WL; i++) if (wl[i]) mr = i;
            if (!in_pulse) begin
                in_pulse = 1;
                plen = 1;
                prow = mr;
                pulses_seen++;
                if (exp_q.size() == 0) begin
                    check_eq("pulse_pending", exp_q.size(), 1);
                end else begin
                    eb = exp_q.pop_front();
                    er = exp_row_q.pop_front();
                    et = exp_t_q.pop_front();
                    check_eq("pulse_row", mr, er);
                    check_eq("pulse_latency", cyc - et, 2);
                    check_eq("pulse_bl", bl, eb);
                end
            end else begin
                plen++;
                check_eq("pulse_row_stable", mr, prow);
            end
        end else if (in_pulse) begin
            in_pulse = 0;
            if (!mon_abort) check_eq("pulse_len", plen, A_P);
            mon_abort = 0;
        end
        if (cyc > last_t && cyc < last_t + 3 + A_P) check_eq("ready_low", ready, 0);
        if (cyc == rdy_chk) check_eq("ready_return", ready, 1);
    end

    // driver tasks, instance A
    task automatic a_send(input int k, input logic [DW-1:0] d, input bit l, input int gap, output int t);
        int guard;
        while ($urandom_range(99) < gap) begin
            valid = 0; data = DW'($urandom); last = 1'($urandom);
            @(negedge clk);
        end
        valid = 1; data = d; last = l; guard = 0;
        while (!ready && guard <= 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard > 200) check_eq("ready_wait", guard, 0);
        for (int i = 0; i < DW; i++) if (k * DW + i < A_BL) model_bl[k * DW + i] = d[i];
        t = cyc;
        @(negedge clk);
    endtask

    // mode 0: good frame, 1: cfg_last on word 5, 2: no cfg_last at all
    task automatic a_frame(input int gap, input int mode, input int start_k);
        int n, t;
        bit l;
        n = (mode == 1) ? 6 : A_W;
        for (int k = 0; k < n; k++) begin
            if (k == start_k) begin
                valid = 0; start = 1;
                @(negedge clk);
                start = 0;
            end
            l = (mode == 0) ? (k == A_W - 1) : ((mode == 1) ? (k == 5) : 1'b0);
            a_send(k, DW'($urandom), l, gap, t);
        end
        if (mode == 0) begin
            exp_q.push_back(model_bl);
            exp_row_q.push_back(model_row);
            exp_t_q.push_back(t);
            last_t = t;
            if (model_row < A_WL - 1) rdy_chk = t + 3 + A_P;
            model_row++;
            check_eq("err_hold", err, exp_err);
        end else begin
            exp_err = 1;
            check_eq("err_set", err, 1);
        end
    endtask

    task automatic a_start();
        valid = 0; start = 1;
        @(negedge clk);
        start = 0;
        model_row = 0;
        exp_err = 0;
    endtask

    task automatic a_wait_done();
        int guard = 0;
        valid = 0;
        while (!done && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("done", done, 1);
        check_eq("done_busy", busy, 0);
        check_eq("done_ready", ready, 0);
        check_eq("done_wl", wl, '0);
    endtask

    // driver task, instance B (valid held high)
    task automatic b_send(input logic [DW-1:0] d, input bit l, output int t);
        int guard = 0;
        b_valid = 1; b_data = d; b_last = l;
        while (!b_ready && guard <= 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard > 50) check_eq("b_ready_wait", guard, 0);
        t = cyc;
        @(negedge clk);
    endtask

    logic [0:B_BL-1] b_model, b_fixed;
    logic [0:B_WL-1] b_wexp;
    logic [DW-1:0]   bw;
    int t, p0, guard;

    initial begin
        rst = 1; start = 0; valid = 0; last = 0; data = '0;
        b_rst = 1; b_start = 0; b_valid = 0; b_last = 0; b_data = '0;
        repeat (3) @(negedge clk);
        rst = 0; b_rst = 0;
        @(negedge clk);
        check_eq("rst_bl", bl, '0);
        check_eq("rst_wl", wl, '0);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);

        // small bank: 3 words per frame, last 4 bits of word 2 discarded
        b_start = 1;
        @(negedge clk);
        b_start = 0;
        check_eq("b_busy", b_busy, 1);
        b_model = '0;
        for (int k = 0; k < 3; k++) begin
            bw = (k == 1) ? 8'h00 : 8'hFF;
            for (int i = 0; i < DW; i++) if (k * DW + i < B_BL) b_model[k * DW + i] = bw[i];
            b_send(bw, k == 2, t);
        end
        b_valid = 0;
        b_fixed = 20'b11111111_00000000_1111;
        check_eq("b_bl_fixed", b_bl, b_fixed);
        check_eq("b_settle_wl", b_wl, '0);
        @(negedge clk);
        b_wexp = 2'b10;
        check_eq("b_wl_row0", b_wl, b_wexp);
        @(negedge clk);
        check_eq("b_hold_wl", b_wl, '0);
        check_eq("b_hold_ready", b_ready, 0);
        @(negedge clk);
        check_eq("b_ready_return", b_ready, 1);
        for (int k = 0; k < 3; k++) begin
            bw = DW'($urandom);
            for (int i = 0; i < DW; i++) if (k * DW + i < B_BL) b_model[k * DW + i] = bw[i];
            b_send(bw, k == 2, t);
        end
        b_valid = 0;
        check_eq("b_bl_row1", b_bl, b_model);
        @(negedge clk);
        b_wexp = 2'b01;
        check_eq("b_wl_row1", b_wl, b_wexp);
        @(negedge clk);
        check_eq("b_hold1_wl", b_wl, '0);
        @(negedge clk);
        check_eq("b_done", b_done, 1);
        check_eq("b_done_busy", b_busy, 0);
        check_eq("b_err", b_err, 0);

        // full bank, valid held high throughout
        pulses_seen = 0;
        a_start();
        check_eq("start_busy", busy, 1);
        check_eq("start_ready", ready, 1);
        for (int r = 0; r < A_WL; r++) a_frame(0, 0, -1);
        a_wait_done();
        check_eq("pulse_count", pulses_seen, A_WL);
        check_eq("err_clean", err, 0);

        // malformed frames, gappy stream, stray cfg_start mid-row
        pulses_seen = 0;
        a_start();
        a_frame(50, 1, -1);
        repeat (6) @(negedge clk);
        check_eq("no_pulse_on_err", pulses_seen, 0);
        for (int r = 0; r < A_WL; r++) begin
            if (r == 50) a_frame(50, 2, -1);
            a_frame(50, 0, (r == 7) ? 9 : -1);
        end
        a_wait_done();
        check_eq("pulse_count_gappy", pulses_seen, A_WL);
        check_eq("err_through_done", err, 1);
        a_start();
        check_eq("err_cleared", err, 0);
        check_eq("restart_busy", busy, 1);

        // reset during the row-3 pulse, cfg_start in the same cycle
        for (int r = 0; r < 4; r++) a_frame(0, 0, -1);
        guard = 0;
        while (!wl[3] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("row3_pulse", wl[3], 1);
        mon_abort = 1;
        rst = 1; start = 1; valid = 0;
        @(negedge clk);
        rst = 0; start = 0;
        exp_q.delete(); exp_row_q.delete(); exp_t_q.delete();
        model_bl = '0; model_row = 0; last_t = -100; rdy_chk = -1; exp_err = 0;
        check_eq("mid_rst_wl", wl, '0);
        check_eq("mid_rst_bl", bl, '0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_ready", ready, 0);
        check_eq("mid_rst_err", err, 0);
        @(negedge clk);
        check_eq("start_under_rst", busy, 0);
        p0 = pulses_seen;
        a_start();
        a_frame(0, 0, -1);
        valid = 0;
        repeat (6) @(negedge clk);
        check_eq("restart_pulse", pulses_seen, p0 + 1);
        check_eq("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
